// File: rtl/riscv_trace_pkg.sv
// Shared types for the commit-trace buffer: event kinds and the packed entry.
// Defining TRACE_TIMESTAMP_EN adds a cycle-stamp field to every entry.
package riscv_trace_pkg;

    localparam int TRACE_ADDR_W = 9;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TS_W   = 16;
    localparam int TRACE_DROP_W = 8;

    typedef enum logic [1:0] {
        MK_NONE     = 2'd0,
        MK_WRITE    = 2'd1,
        MK_READ     = 2'd2,
        MK_CONFLICT = 2'd3
    } mem_kind_e;

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0]   ts;
`endif
        logic                    reg_v;
        logic [4:0]              reg_num;
        logic [TRACE_DATA_W-1:0] reg_data;
        mem_kind_e               mem_kind;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] mem_data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with flush; async active-low reset.
// Ports: push/wdata in, pop/rdata out (rdata=0 when empty), full/empty/level.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == LVL_W'(DEPTH));
    assign level = cnt_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            cnt_d = cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Packs core reg-write / data-memory events into trace entries and queues them.
// Ports: core observation inputs, clear, valid/ready drain, overflow/drop/frozen/level status.
// Optional TRACE_TIMESTAMP_EN stamps each entry with a free-running cycle count.
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int TS_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reg_write_sig,
    input  logic [4:0]              reg_num,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       rd_data,
    input  logic                    Halt_riscv,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output trace_entry_t            out_entry,
    output logic                    overflow,
    output logic [TRACE_DROP_W-1:0] drop_count,
    output logic                    frozen,
    output logic [$clog2(DEPTH):0]  level
);

    if (ADDR_W != TRACE_ADDR_W || DATA_W != TRACE_DATA_W ||
        TS_W != TRACE_TS_W) begin : g_bad_cfg
        $error("widths must match riscv_trace_pkg");
    end

    typedef enum logic {CAPTURE = 1'b0, FROZEN = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    ovf_q, ovf_d;
    logic [TRACE_DROP_W-1:0] drop_q, drop_d;
    trace_entry_t            ent;
    logic                    ev, pop, drop;
    logic                    full, empty;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = clear ? '0 : ts_q + TS_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`endif

    assign ev   = (state_q == CAPTURE) && (reg_write_sig || wr || rd);
    assign pop  = out_valid && out_ready && !clear;
    assign drop = ev && !clear && full && !pop;

    always_comb begin
        ent = '0;
`ifdef TRACE_TIMESTAMP_EN
        ent.ts = ts_q;
`endif
        if (reg_write_sig) begin
            ent.reg_v    = 1'b1;
            ent.reg_num  = reg_num;
            ent.reg_data = reg_data;
        end
        unique case (1'b1)
            (wr && rd): begin
                ent.mem_kind = MK_CONFLICT;
                ent.addr     = addr;
                ent.mem_data = wr_data;
            end
            (wr && !rd): begin
                ent.mem_kind = MK_WRITE;
                ent.addr     = addr;
                ent.mem_data = wr_data;
            end
            (rd && !wr): begin
                ent.mem_kind = MK_READ;
                ent.addr     = addr;
                ent.mem_data = rd_data;
            end
            default: ent.mem_kind = MK_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (clear) begin
            state_d = CAPTURE;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            if (state_q == CAPTURE && Halt_riscv) state_d = FROZEN;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + TRACE_DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CAPTURE;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trace_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (ev),
        .wdata (ent),
        .pop   (pop),
        .rdata (out_entry),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid  = !empty;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign frozen     = (state_q == FROZEN);

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Scoreboard bench for riscv_trace_buffer: directed events, queued expectations,
// a negedge monitor comparing every popped entry.
module tb_riscv_trace_buffer;
    import riscv_trace_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         reg_write_sig = 1'b0;
    logic [4:0]   reg_num = '0;
    logic [31:0]  reg_data = '0;
    logic         wr = 1'b0;
    logic         rd = 1'b0;
    logic [8:0]   addr = '0;
    logic [31:0]  wr_data = '0;
    logic [31:0]  rd_data = '0;
    logic         Halt_riscv = 1'b0;
    logic         clear = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    trace_entry_t out_entry;
    logic         overflow;
    logic [7:0]   drop_count;
    logic         frozen;
    logic [4:0]   level;

    int n_cmp = 0;
    int n_bad = 0;
    trace_entry_t exp_q[$];

    always #5 clk = ~clk;

    riscv_trace_buffer dut (
        .clk           (clk),
        .reset         (rst_n),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .Halt_riscv    (Halt_riscv),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_entry     (out_entry),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .frozen        (frozen),
        .level         (level)
    );

    function automatic trace_entry_t mk(input logic rv, input logic [4:0] rn,
                                        input logic [31:0] rdv, input mem_kind_e k,
                                        input logic [8:0] a, input logic [31:0] md);
        trace_entry_t e;
        e = '0;
        e.reg_v    = rv;
        e.reg_num  = rn;
        e.reg_data = rdv;
        e.mem_kind = k;
        e.addr     = a;
        e.mem_data = md;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: every accepted handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            trace_entry_t g, w;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got %h want none", out_entry);
            end else begin
                w = exp_q.pop_front();
                g = out_entry;
`ifdef TRACE_TIMESTAMP_EN
                g.ts = '0;
                w.ts = '0;
`endif
                if (g !== w) begin
                    n_bad++;
                    $display("FAIL sb_entry: got %h want %h", g, w);
                end
            end
        end
    end

    task automatic idle();
        reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
        wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
        Halt_riscv = 1'b0;
    endtask

    task automatic drive(input logic rw, input logic [4:0] rn, input logic [31:0] rdv,
                         input logic w, input logic r, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] rdd);
        reg_write_sig = rw; reg_num = rn; reg_data = rdv;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((level != 0 || exp_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", 32'(n < 100), 32'd1);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_entry", 32'(out_entry), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf_drop_frz", {22'd0, overflow, drop_count, frozen}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single reg write; no bypass, valid the next cycle
        exp_q.push_back(mk(1, 5, 32'h2A, MK_NONE, 0, 0));
        reg_write_sig = 1; reg_num = 5; reg_data = 32'h2A;
        #1 chk("t1_no_bypass", 32'(out_valid), 0);
        @(posedge clk); #1;
        idle();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_reg_num", 32'(out_entry.reg_num), 5);
        chk("t1_kind", 32'(out_entry.mem_kind), 32'(MK_NONE));
        drain();

        // 2: read + reg write in one cycle -> one entry
        exp_q.push_back(mk(1, 7, 32'h1234, MK_READ, 9'h10, 32'hDEADBEEF));
        drive(1, 7, 32'h1234, 0, 1, 9'h10, 32'h0, 32'hDEADBEEF);
        chk("t2_level", 32'(level), 1);
        drain();

        // 3: 20 writes into a 16-deep FIFO with no drain
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(mk(0, 0, 0, MK_WRITE, 9'(i), 32'h100 + i));
            drive(0, 0, 0, 1, 0, 9'(i), 32'h100 + i, 32'hFFFF);
        end
        chk("t3_level", 32'(level), 16);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_drop", 32'(drop_count), 4);

        // 4: full + pop + conflicting event in the same cycle
        exp_q.push_back(mk(1, 3, 32'h55, MK_CONFLICT, 9'h1FF, 32'hCAFE));
        out_ready = 1'b1;
        drive(1, 3, 32'h55, 1, 1, 9'h1FF, 32'hCAFE, 32'hBAD);
        out_ready = 1'b0;
        chk("t4_level", 32'(level), 16);
        chk("t4_drop", 32'(drop_count), 4);
        drain();
        chk("t4_ovf_sticky", 32'(overflow), 1);
        do_clear();
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_count), 0);

        // 5: halt cycle captured, later events ignored
        exp_q.push_back(mk(1, 1, 32'h11, MK_NONE, 0, 0));
        drive(1, 1, 32'h11, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, MK_READ, 9'h22, 32'h22));
        drive(0, 0, 0, 0, 1, 9'h22, 32'h99, 32'h22);
        exp_q.push_back(mk(1, 2, 32'h33, MK_NONE, 0, 0));
        Halt_riscv = 1'b1;
        drive(1, 2, 32'h33, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 9, 32'h77, 1, 0, 9'h5, 32'h77, 0);
        chk("t5_frozen", 32'(frozen), 1);
        chk("t5_level", 32'(level), 3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_drain_frozen", 32'(level), 2);
        do_clear();
        exp_q.delete();
        chk("t5_clr_level", 32'(level), 0);
        chk("t5_clr_frozen", 32'(frozen), 0);
        chk("t5_clr_ovf", 32'(overflow), 0);
        exp_q.push_back(mk(1, 4, 32'h44, MK_NONE, 0, 0));
        drive(1, 4, 32'h44, 0, 0, 0, 0, 0);
        chk("t5_recapture", 32'(level), 1);
        drain();

        // 6: async reset mid-burst
        for (int i = 0; i < 7; i++) drive(1, 5'(i), 32'(i), 0, 0, 0, 0, 0);
        chk("t6_level7", 32'(level), 7);
        chk("t6_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_entry", 32'(out_entry), 0);
        chk("t6_rst_level", 32'(level), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 0, MK_WRITE, 9'h0AB, 32'hFACE));
        drive(0, 0, 0, 1, 0, 9'h0AB, 32'hFACE, 0);
        chk("t6_resume", 32'(level), 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
